// File: rtl/trigger_event_capture.sv
// Trigger event capture: timestamps rising stage flags into a small record
// FIFO and fires one width-programmable external trigger pulse per arm.
// Ports: rxclk/adc_rst (clock, async active-high reset), trig_enable (arm;
// low = synchronous clear), detect_pls[4:1] (stage flags), pulse_tof and
// trig_width (sampled data/config), trig_out (registered trigger),
// evt_valid/evt_ready (record handshake), evt_mask/evt_tstamp/evt_tof (head
// record), evt_level (occupancy), evt_overflow (sticky drop flag).
// Latency: a captured record is visible on evt_valid the edge after capture.
// Backpressure: records queue while evt_ready is low; a capture into a full
// FIFO without a same-cycle pop is dropped and flags evt_overflow.
module trigger_event_capture #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                            rxclk,
    input  logic                            adc_rst,
    input  logic                            trig_enable,
    input  logic [7:0]                      detect_pls,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   pulse_tof,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   trig_width,
    output logic                            trig_out,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [3:0]                      evt_mask,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   evt_tstamp,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   evt_tof,
    output logic [$clog2(FIFO_DEPTH):0]     evt_level,
    output logic                            evt_overflow
);

    localparam int W  = C_S_AXI_DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Only stage flags [4:1] carry meaning; the rest are deliberately dropped.
    logic unused_pls;
    assign unused_pls = ^{detect_pls[7:5], detect_pls[0]};

    logic [W-1:0]  tstamp;
    logic [3:0]    prev;
    logic [3:0]    rise;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          overflow;

    logic [3:0]    mem_mask [FIFO_DEPTH];
    logic [W-1:0]  mem_ts   [FIFO_DEPTH];
    logic [W-1:0]  mem_tof  [FIFO_DEPTH];

    logic          capture;
    logic          full;
    logic          pop;
    logic          wr_en;

    state_t        state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic          trig_q, trig_d;

    // Gating rise with trig_enable means a rise on the clearing edge is lost.
    assign rise    = detect_pls[4:1] & ~prev;
    assign capture = trig_enable && (rise != 4'd0);
    assign full    = (level == LW'(FIFO_DEPTH));
    assign pop     = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign wr_en   = capture && (!full || pop);

    // ---------------------------------------------------------------
    // Timestamp, edge history and FIFO bookkeeping
    // ---------------------------------------------------------------
    always_ff @(posedge rxclk or posedge adc_rst) begin
        if (adc_rst) begin
            tstamp   <= '0;
            prev     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (!trig_enable) begin
            tstamp   <= '0;
            prev     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            tstamp <= tstamp + W'(1);
            prev   <= detect_pls[4:1];
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (capture && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: it is only observed through valid-gated outputs.
    always_ff @(posedge rxclk) begin
        if (wr_en) begin
            mem_mask[wr_ptr] <= rise;
            mem_ts[wr_ptr]   <= tstamp;
            mem_tof[wr_ptr]  <= pulse_tof;
        end
    end

    assign evt_valid    = (level != '0);
    assign evt_level    = level;
    assign evt_overflow = overflow;
    assign evt_mask     = evt_valid ? mem_mask[rd_ptr] : 4'd0;
    assign evt_tstamp   = evt_valid ? mem_ts[rd_ptr]   : '0;
    assign evt_tof      = evt_valid ? mem_tof[rd_ptr]  : '0;

    // ---------------------------------------------------------------
    // Trigger pulse FSM
    // ---------------------------------------------------------------
    always_ff @(posedge rxclk or posedge adc_rst) begin
        if (adc_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        if (!trig_enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            trig_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise[3]) begin
                        state_d = PULSE;
                        // Width is latched here so later changes cannot stretch it.
                        cnt_d   = (trig_width == '0) ? W'(1) : trig_width;
                        trig_d  = 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt_q <= W'(1)) begin
                        state_d = DONE;
                        trig_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - W'(1);
                    end
                end
                DONE: begin
                    // One trigger per arm: wait here until trig_enable drops.
                    trig_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    trig_d  = 1'b0;
                end
            endcase
        end
    end

    assign trig_out = trig_q;

endmodule

// File: tb/tb_trigger_event_capture.sv
module tb_trigger_event_capture;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic             rxclk;
    logic             adc_rst;
    logic             trig_enable;
    logic [7:0]       detect_pls;
    logic [W-1:0]     pulse_tof;
    logic [W-1:0]     trig_width;
    logic             trig_out;
    logic             evt_valid;
    logic             evt_ready;
    logic [3:0]       evt_mask;
    logic [W-1:0]     evt_tstamp;
    logic [W-1:0]     evt_tof;
    logic [$clog2(DEPTH):0] evt_level;
    logic             evt_overflow;

    trigger_event_capture #(
        .C_S_AXI_DATA_WIDTH(W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .rxclk       (rxclk),
        .adc_rst     (adc_rst),
        .trig_enable (trig_enable),
        .detect_pls  (detect_pls),
        .pulse_tof   (pulse_tof),
        .trig_width  (trig_width),
        .trig_out    (trig_out),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_mask    (evt_mask),
        .evt_tstamp  (evt_tstamp),
        .evt_tof     (evt_tof),
        .evt_level   (evt_level),
        .evt_overflow(evt_overflow)
    );

    initial rxclk = 1'b0;
    always #4 rxclk = ~rxclk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of records, a cycle counter and a count of
    // trigger-high cycles still owed.
    typedef struct packed {
        logic [3:0]   m;
        logic [W-1:0] ts;
        logic [W-1:0] tof;
    } rec_t;

    rec_t         q[$];
    logic [W-1:0] m_ts;
    logic [3:0]   m_prev;
    bit           m_ovf;
    longint       m_pulse;
    bit           m_fired;

    task automatic model_clear();
        q.delete();
        m_ts    = '0;
        m_prev  = '0;
        m_ovf   = 1'b0;
        m_pulse = 0;
        m_fired = 1'b0;
    endtask

    task automatic model_edge();
        logic [3:0] r;
        bit         pop;
        rec_t       rec;
        if (!trig_enable) begin
            model_clear();
            return;
        end
        r   = detect_pls[4:1] & ~m_prev;
        pop = (q.size() != 0) && evt_ready;
        if (m_pulse > 0) begin
            m_pulse--;
        end else if (!m_fired && r[3]) begin
            m_fired = 1'b1;
            m_pulse = (trig_width == 0) ? 1 : longint'(trig_width);
        end
        if (pop) void'(q.pop_front());
        if (r != 4'd0) begin
            if (q.size() < DEPTH) begin
                rec.m   = r;
                rec.ts  = m_ts;
                rec.tof = pulse_tof;
                q.push_back(rec);
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_prev = detect_pls[4:1];
        m_ts   = m_ts + 1;
    endtask

    task automatic compare_all();
        check("trig_out", trig_out, (m_pulse > 0));
        check("evt_valid", evt_valid, (q.size() != 0));
        check("evt_level", evt_level, q.size());
        check("evt_overflow", evt_overflow, m_ovf);
        if (q.size() != 0) begin
            check("evt_mask", evt_mask, q[0].m);
            check("evt_tstamp", evt_tstamp, q[0].ts);
            check("evt_tof", evt_tof, q[0].tof);
        end
    endtask

    // Called at a falling edge: drive, clock once, update model, compare.
    task automatic step(input logic en, input logic [7:0] dp, input logic [W-1:0] tof,
                        input logic [W-1:0] tw, input logic rdy);
        trig_enable = en;
        detect_pls  = dp;
        pulse_tof   = tof;
        trig_width  = tw;
        evt_ready   = rdy;
        @(posedge rxclk);
        model_edge();
        @(negedge rxclk);
        compare_all();
    endtask

    task automatic rearm();
        step(1'b0, 8'h00, 0, 0, 1'b0);
        step(1'b1, 8'h00, 0, 0, 1'b0);
    endtask

    int hi;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        adc_rst     = 1'b1;
        trig_enable = 1'b0;
        detect_pls  = 8'h00;
        pulse_tof   = '0;
        trig_width  = '0;
        evt_ready   = 1'b0;
        model_clear();
        repeat (2) @(negedge rxclk);
        check("rst_trig_out", trig_out, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_level", evt_level, 0);
        check("rst_evt_overflow", evt_overflow, 0);
        check("rst_evt_mask", evt_mask, 0);
        check("rst_evt_tstamp", evt_tstamp, 0);
        check("rst_evt_tof", evt_tof, 0);
        adc_rst = 1'b0;

        // Single rise at ts=10
        repeat (10) step(1'b1, 8'h00, 0, 0, 1'b0);
        step(1'b1, 8'h02, 32'h1234, 0, 1'b0);
        check("d38_mask", evt_mask, 4'h1);
        check("d38_tstamp", evt_tstamp, 10);
        check("d38_tof", evt_tof, 32'h1234);
        check("d38_trig", trig_out, 0);
        check("d38_level", evt_level, 1);

        // All four stages at ts=50, width 5; width change mid-pulse ignored
        while (m_ts < 49) step(1'b1, 8'h02, 0, 0, 1'b1);
        step(1'b1, 8'h00, 0, 0, 1'b1);
        step(1'b1, 8'h1E, 32'hABCD, 5, 1'b0);
        check("d39_mask", evt_mask, 4'hF);
        check("d39_tstamp", evt_tstamp, 50);
        check("d39_level", evt_level, 1);
        hi = trig_out ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h1E, 0, 9, 1'b1);
            if (trig_out) hi++;
        end
        check("d39_width5", hi, 5);
        step(1'b1, 8'h00, 0, 5, 1'b1);
        step(1'b1, 8'h10, 0, 5, 1'b1);
        check("d39_no_retrigger", trig_out, 0);
        repeat (3) step(1'b1, 8'h10, 0, 5, 1'b1);

        // Zero width gives one cycle
        rearm();
        step(1'b1, 8'h10, 0, 0, 1'b1);
        hi = trig_out ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h10, 0, 0, 1'b1);
            if (trig_out) hi++;
        end
        check("d40_width0", hi, 1);

        // Overflow: 5 captures, no consumer
        rearm();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h02, 32'h100 + i, 0, 1'b0);
            step(1'b1, 8'h00, 0, 0, 1'b0);
        end
        check("d41_level", evt_level, 4);
        check("d41_overflow", evt_overflow, 1);
        check("d41_head_tof", evt_tof, 32'h100);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 0, 0, 1'b1);
        check("d41_drained", evt_valid, 0);

        // Full with simultaneous capture and pop
        rearm();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h04, 32'h200 + i, 0, 1'b0);
            step(1'b1, 8'h00, 0, 0, 1'b0);
        end
        step(1'b1, 8'h08, 32'h2FF, 0, 1'b1);
        check("d42_level", evt_level, 4);
        check("d42_overflow", evt_overflow, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 0, 0, 1'b1);
        check("d42_last_tof", evt_tof, 32'h2FF);
        step(1'b1, 8'h00, 0, 0, 1'b1);

        // Async reset mid-pulse with two records queued
        rearm();
        step(1'b1, 8'h10, 32'h300, 20, 1'b0);
        step(1'b1, 8'h12, 32'h301, 20, 1'b0);
        step(1'b1, 8'h12, 0, 20, 1'b0);
        check("d43_pre_level", evt_level, 2);
        check("d43_pre_trig", trig_out, 1);
        #1 adc_rst = 1'b1;
        #1;
        check("d43_async_trig", trig_out, 0);
        check("d43_async_valid", evt_valid, 0);
        check("d43_async_level", evt_level, 0);
        model_clear();
        @(negedge rxclk);
        @(negedge rxclk);
        adc_rst = 1'b0;
        step(1'b1, 8'h02, 32'h400, 0, 1'b0);
        check("d43_restart_tstamp", evt_tstamp, 0);
        step(1'b1, 8'h00, 0, 0, 1'b1);

        // Randomized traffic
        begin
            logic [7:0] dp;
            int         rdy_pct;
            dp      = 8'h00;
            rdy_pct = 70;
            for (int c = 0; c < 2000; c++) begin
                if (c % 64 == 0) rdy_pct = $urandom_range(0, 100);
                if ($urandom_range(0, 3) == 0) dp = 8'($urandom);
                step($urandom_range(0, 59) != 0, dp, $urandom, $urandom_range(0, 6),
                     $urandom_range(0, 99) < rdy_pct);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
